// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate / RGB link between the VGA timing generator and the renderer.
// The timing generator drives coordinates and strobes; the renderer returns colour.
interface vga_timing_gen_if;
    logic [9:0] col;
    logic [8:0] row;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;

    modport master (
        output col, row, display_on, line_start, frame_start,
        input  red_in, green_in, blue_in
    );

    modport slave (
        input  col, row, display_on, line_start, frame_start,
        output red_in, green_in, blue_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing generator: drives pixel coordinates to a renderer and
// re-times the returned colour, syncs and blanking onto registered VGA pins.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic             vga_clk,
    input  logic             rst,
    vga_timing_gen_if.master pix,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam logic [9:0] HLast   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VLast   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HActive = 10'(H_ACTIVE);
    localparam logic [9:0] VActive = 10'(V_ACTIVE);
    localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    logic h_act, v_act, de_raw, hs_raw, vs_raw;

    // Bit i holds the raw signal delayed by i+1 cycles.
    logic [PIPE_DLY-1:0] de_sr_q, de_sr_d;
    logic [PIPE_DLY-1:0] hs_sr_q, hs_sr_d;
    logic [PIPE_DLY-1:0] vs_sr_q, vs_sr_d;

    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end
    end

    // Renderer-facing strobes decode the live counters and are masked during reset.
    always_comb begin
        h_act  = h_cnt_q < HActive;
        v_act  = v_cnt_q < VActive;
        de_raw = h_act && v_act;
        hs_raw = (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd);
        vs_raw = (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd);

        pix.display_on  = !rst && de_raw;
        pix.col         = (!rst && de_raw) ? h_cnt_q : '0;
        pix.row         = (!rst && de_raw) ? v_cnt_q[8:0] : '0;
        pix.line_start  = !rst && v_act && (h_cnt_q == '0);
        pix.frame_start = !rst && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        de_sr_d    = de_sr_q;
        hs_sr_d    = hs_sr_q;
        vs_sr_d    = vs_sr_q;
        de_sr_d[0] = de_raw;
        hs_sr_d[0] = hs_raw;
        vs_sr_d[0] = vs_raw;
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
            de_sr_d[i] = de_sr_q[i-1];
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end
    end

    // Colour arriving with the delayed blank flag lines up with the delayed syncs.
    always_comb begin
        vga_hs_d = hs_sr_q[PIPE_DLY-1] ? SYNC_POL : ~SYNC_POL;
        vga_vs_d = vs_sr_q[PIPE_DLY-1] ? SYNC_POL : ~SYNC_POL;
        vga_r_d  = de_sr_q[PIPE_DLY-1] ? pix.red_in   : 4'h0;
        vga_g_d  = de_sr_q[PIPE_DLY-1] ? pix.green_in : 4'h0;
        vga_b_d  = de_sr_q[PIPE_DLY-1] ? pix.blue_in  : 4'h0;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            de_sr_q  <= '0;
            hs_sr_q  <= '0;
            vs_sr_q  <= '0;
            vga_hs_q <= ~SYNC_POL;
            vga_vs_q <= ~SYNC_POL;
            vga_r_q  <= 4'h0;
            vga_g_q  <= 4'h0;
            vga_b_q  <= 4'h0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            de_sr_q  <= de_sr_d;
            hs_sr_q  <= hs_sr_d;
            vs_sr_q  <= vs_sr_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
        end
    end

    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;
    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken-timing instances, PIPE_DLY 1 and 3,
// checked against an arithmetic position model driven by a cycle count since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int fp; int hs; int bp; int va; int vfp; int vs; int vbp;
    } cfg_t;

    localparam int S_HA = 16, S_FP = 4, S_HS = 6, S_BP = 6;
    localparam int S_VA = 8, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam cfg_t CF = '{ha: 640, fp: 16, hs: 96, bp: 48, va: 480, vfp: 10, vs: 2, vbp: 33};
    localparam cfg_t CS = '{ha: S_HA, fp: S_FP, hs: S_HS, bp: S_BP,
                            va: S_VA, vfp: S_VFP, vs: S_VS, vbp: S_VBP};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if if_f ();
    vga_timing_gen_if if_s1 ();
    vga_timing_gen_if if_s3 ();

    logic hs_f, vs_f, hs_s1, vs_s1, hs_s3, vs_s3;
    logic [3:0] r_f, g_f, b_f, r_s1, g_s1, b_s1, r_s3, g_s3, b_s3;

    vga_timing_gen u_full (
        .vga_clk(clk), .rst(rst), .pix(if_f),
        .vga_hs(hs_f), .vga_vs(vs_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_FP), .H_SYNC(S_HS), .H_BP(S_BP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PIPE_DLY(1)
    ) u_s1 (
        .vga_clk(clk), .rst(rst), .pix(if_s1),
        .vga_hs(hs_s1), .vga_vs(vs_s1), .vga_r(r_s1), .vga_g(g_s1), .vga_b(b_s1)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_FP), .H_SYNC(S_HS), .H_BP(S_BP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .PIPE_DLY(3)
    ) u_s3 (
        .vga_clk(clk), .rst(rst), .pix(if_s3),
        .vga_hs(hs_s3), .vga_vs(vs_s3), .vga_r(r_s3), .vga_g(g_s3), .vga_b(b_s3)
    );

    int errors = 0;
    int checks = 0;
    int k = 0;              // cycles since the counters were last reset to (0,0)
    bit const_mode = 1'b0;
    logic [11:0] hist [0:8191];
    logic [3:0] e0 = '0, e1 = '0, e2 = '0;

    function automatic int m_h(cfg_t c, int kk);
        return kk % (c.ha + c.fp + c.hs + c.bp);
    endfunction

    function automatic int m_v(cfg_t c, int kk);
        return (kk / (c.ha + c.fp + c.hs + c.bp)) % (c.va + c.vfp + c.vs + c.vbp);
    endfunction

    // {col, row, display_on, line_start, frame_start}
    function automatic logic [21:0] exp_dec(cfg_t c, int kk, logic in_rst);
        int h, v;
        bit de;
        h  = m_h(c, kk);
        v  = m_v(c, kk);
        de = (h < c.ha) && (v < c.va);
        if (in_rst) return '0;
        return {de ? 10'(h) : 10'd0, de ? 9'(v) : 9'd0, de, (h == 0) && (v < c.va),
                (h == 0) && (v == 0)};
    endfunction

    // {hs, vs, r, g, b}: pins show the pixel from p+1 cycles ago, idle before that.
    function automatic logic [13:0] exp_pins(cfg_t c, int p, int kk, logic [11:0] rgb);
        int s, h, v;
        bit de, hs, vs;
        if (kk < p + 1) return 14'h3000;
        s  = kk - p - 1;
        h  = m_h(c, s);
        v  = m_v(c, s);
        de = (h < c.ha) && (v < c.va);
        hs = (h >= c.ha + c.fp) && (h < c.ha + c.fp + c.hs);
        vs = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
        return {~hs, ~vs, de ? rgb : 12'h000};
    endfunction

    function automatic logic [11:0] prev_rgb();
        return (k > 0) ? hist[(k - 1) % 8192] : 12'h000;
    endfunction

    task automatic tick(input logic rst_v);
        logic [11:0] rgb;
        @(posedge clk);
        #1;
        k   = rst ? 0 : k + 1;
        rst = rst_v;
        rgb = const_mode ? 12'hF80 : 12'($urandom);
        hist[k % 8192] = rgb;
        {if_f.red_in, if_f.green_in, if_f.blue_in}    = rgb;
        {if_s1.red_in, if_s1.green_in, if_s1.blue_in} = rgb;
        if_s3.red_in   = e2;
        if_s3.green_in = rgb[7:4];
        if_s3.blue_in  = rgb[3:0];
        #1;
        e2 = e1;
        e1 = e0;
        e0 = if_s3.col[3:0];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            checks++;
            if ({hs_f, vs_f, r_f, g_f, b_f} !== 14'h3000) begin
                errors++;
                $display("FAIL reset_pins_full: got %h want %h", {hs_f, vs_f, r_f, g_f, b_f}, 14'h3000);
            end
            checks++;
            if ({hs_s1, vs_s1, r_s1, g_s1, b_s1} !== 14'h3000) begin
                errors++;
                $display("FAIL reset_pins_s1: got %h want %h", {hs_s1, vs_s1, r_s1, g_s1, b_s1}, 14'h3000);
            end
            checks++;
            if ({hs_s3, vs_s3, r_s3, g_s3, b_s3} !== 14'h3000) begin
                errors++;
                $display("FAIL reset_pins_s3: got %h want %h", {hs_s3, vs_s3, r_s3, g_s3, b_s3}, 14'h3000);
            end
            checks++;
            if ({if_s1.display_on, if_s1.line_start, if_s1.frame_start} !== 3'b000) begin
                errors++;
                $display("FAIL reset_strobes: got %b want 000",
                         {if_s1.display_on, if_s1.line_start, if_s1.frame_start});
            end
        end
        tick(1'b0);
        checks++;
        if ({if_f.col, if_f.row, if_f.display_on, if_f.line_start, if_f.frame_start} !== 22'h7) begin
            errors++;
            $display("FAIL release_full: got %h want %h",
                     {if_f.col, if_f.row, if_f.display_on, if_f.line_start, if_f.frame_start}, 22'h7);
        end
        checks++;
        if ({if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start} !== 22'h7) begin
            errors++;
            $display("FAIL release_s1: got %h want %h",
                     {if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start}, 22'h7);
        end
    endtask

    task automatic test_line_full();
        int fall1 = -1, fall2 = -1, width = 0;
        logic prev;
        logic [13:0] ep;
        logic [21:0] ed;
        prev = hs_f;
        repeat (1600) begin
            tick(1'b0);
            ep = exp_pins(CF, 1, k, prev_rgb());
            ed = exp_dec(CF, k, rst);
            checks++;
            if ({hs_f, vs_f, r_f, g_f, b_f} !== ep) begin
                errors++;
                $display("FAIL full_pins k=%0d: got %h want %h", k, {hs_f, vs_f, r_f, g_f, b_f}, ep);
            end
            checks++;
            if ({if_f.col, if_f.row, if_f.display_on, if_f.line_start, if_f.frame_start} !== ed) begin
                errors++;
                $display("FAIL full_decode k=%0d: got %h want %h", k,
                         {if_f.col, if_f.row, if_f.display_on, if_f.line_start, if_f.frame_start}, ed);
            end
            if (prev && !hs_f) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!hs_f && fall2 < 0) width++;
            prev = hs_f;
        end
        checks++;
        if (fall1 != 658) begin
            errors++;
            $display("FAIL hsync_first_low: got %0d want 658", fall1);
        end
        checks++;
        if (width != 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d want 96", width);
        end
        checks++;
        if (fall2 - fall1 != 800) begin
            errors++;
            $display("FAIL hsync_period: got %0d want 800", fall2 - fall1);
        end
    endtask

    task automatic test_frames();
        int fs = 0, ls = 0, vs_lo = 0, last_fs = -1;
        logic [13:0] ep, ep3;
        logic [21:0] ed;
        repeat (960) begin
            tick(1'b0);
            ep  = exp_pins(CS, 1, k, prev_rgb());
            ep3 = exp_pins(CS, 3, k, prev_rgb());
            ed  = exp_dec(CS, k, rst);
            checks++;
            if ({hs_s1, vs_s1, r_s1, g_s1, b_s1} !== ep) begin
                errors++;
                $display("FAIL s1_pins k=%0d: got %h want %h", k, {hs_s1, vs_s1, r_s1, g_s1, b_s1}, ep);
            end
            checks++;
            if ({hs_s3, vs_s3, g_s3, b_s3} !== {ep3[13:12], ep3[7:0]}) begin
                errors++;
                $display("FAIL s3_pins k=%0d: got %h want %h", k, {hs_s3, vs_s3, g_s3, b_s3},
                         {ep3[13:12], ep3[7:0]});
            end
            checks++;
            if ({if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start} !== ed) begin
                errors++;
                $display("FAIL s1_decode k=%0d: got %h want %h", k,
                         {if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start}, ed);
            end
            checks++;
            if ({if_s3.col, if_s3.row, if_s3.display_on, if_s3.line_start, if_s3.frame_start} !== ed) begin
                errors++;
                $display("FAIL s3_decode k=%0d: got %h want %h", k,
                         {if_s3.col, if_s3.row, if_s3.display_on, if_s3.line_start, if_s3.frame_start}, ed);
            end
            if (if_s1.frame_start) begin
                fs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (k - last_fs != 480) begin
                        errors++;
                        $display("FAIL frame_period: got %0d want 480", k - last_fs);
                    end
                end
                last_fs = k;
            end
            if (if_s1.line_start) ls++;
            if (!vs_s1) vs_lo++;
        end
        checks++;
        if (fs != 2) begin
            errors++;
            $display("FAIL frame_start_count: got %0d want 2", fs);
        end
        checks++;
        if (ls != 16) begin
            errors++;
            $display("FAIL line_start_count: got %0d want 16", ls);
        end
        checks++;
        if (vs_lo != 128) begin
            errors++;
            $display("FAIL vsync_low_cycles: got %0d want 128", vs_lo);
        end
    endtask

    task automatic test_colour_const();
        int n = 0, run = 0, runs = 0, total = 0;
        const_mode = 1'b1;
        while (!if_s1.frame_start && n < 600) begin
            tick(1'b0);
            n++;
        end
        checks++;
        if (if_s1.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL colour_wait_frame: got %b want 1", if_s1.frame_start);
        end
        repeat (481) begin
            tick(1'b0);
            checks++;
            if (!((r_s1 == 4'hF && g_s1 == 4'h8) || (r_s1 == 4'h0 && g_s1 == 4'h0)) || b_s1 != 4'h0) begin
                errors++;
                $display("FAIL colour_value k=%0d: got %h want F80 or 000", k, {r_s1, g_s1, b_s1});
            end
            if (r_s1 == 4'hF) begin
                run++;
                total++;
            end else if (run != 0) begin
                checks++;
                if (run != 16) begin
                    errors++;
                    $display("FAIL colour_run_len: got %0d want 16", run);
                end
                runs++;
                run = 0;
            end
        end
        checks++;
        if (runs != 8 || total != 128) begin
            errors++;
            $display("FAIL colour_lines: got %0d runs %0d cycles want 8 runs 128 cycles", runs, total);
        end
        const_mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        logic [13:0] ep, ep3;
        while (!(m_h(CS, k) == 24 && m_v(CS, k) == 5) && n < 600) begin
            tick(1'b0);
            n++;
        end
        checks++;
        if (hs_s1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_arrive_in_sync: got %b want 0", hs_s1);
        end
        tick(1'b1);
        checks++;
        if ({if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start,
             if_f.display_on, if_f.frame_start} !== 24'h0) begin
            errors++;
            $display("FAIL mid_rst_strobes: got %h want 0",
                     {if_s1.col, if_s1.row, if_s1.display_on, if_s1.line_start, if_s1.frame_start,
                      if_f.display_on, if_f.frame_start});
        end
        tick(1'b0);
        checks++;
        if ({if_s1.col, if_s1.row, if_s1.display_on, if_s1.frame_start} !== 21'h3) begin
            errors++;
            $display("FAIL mid_release: got %h want %h",
                     {if_s1.col, if_s1.row, if_s1.display_on, if_s1.frame_start}, 21'h3);
        end
        checks++;
        if ({hs_s1, vs_s1, r_s1, g_s1, b_s1, hs_s3, vs_s3, r_s3} !== {14'h3000, 6'b110000}) begin
            errors++;
            $display("FAIL mid_flushed: got %h want %h",
                     {hs_s1, vs_s1, r_s1, g_s1, b_s1, hs_s3, vs_s3, r_s3}, {14'h3000, 6'b110000});
        end
        repeat (6) begin
            tick(1'b0);
            ep  = exp_pins(CS, 1, k, prev_rgb());
            ep3 = exp_pins(CS, 3, k, prev_rgb());
            checks++;
            if ({hs_s1, vs_s1, r_s1, g_s1, b_s1, hs_s3, vs_s3, g_s3, b_s3} !==
                {ep, ep3[13:12], ep3[7:0]}) begin
                errors++;
                $display("FAIL mid_refill k=%0d: got %h want %h", k,
                         {hs_s1, vs_s1, r_s1, g_s1, b_s1, hs_s3, vs_s3, g_s3, b_s3},
                         {ep, ep3[13:12], ep3[7:0]});
            end
        end
    endtask

    task automatic test_pipe3();
        int falls = 0, s;
        logic prev;
        logic [3:0] er;
        prev = hs_s3;
        repeat (480) begin
            tick(1'b0);
            s  = k - 4;
            er = (s >= 0 && m_h(CS, s) < S_HA && m_v(CS, s) < S_VA) ? 4'(m_h(CS, s)) : 4'h0;
            checks++;
            if (r_s3 !== er) begin
                errors++;
                $display("FAIL pipe3_echo k=%0d: got %h want %h", k, r_s3, er);
            end
            if (prev && !hs_s3) begin
                falls++;
                checks++;
                if (m_h(CS, k) != 24) begin
                    errors++;
                    $display("FAIL pipe3_hs_fall: got h=%0d want 24", m_h(CS, k));
                end
            end
            prev = hs_s3;
        end
        checks++;
        if (falls != 15) begin
            errors++;
            $display("FAIL pipe3_hs_falls: got %0d want 15", falls);
        end
    endtask

    initial begin
        {if_f.red_in, if_f.green_in, if_f.blue_in}    = 12'h000;
        {if_s1.red_in, if_s1.green_in, if_s1.blue_in} = 12'h000;
        {if_s3.red_in, if_s3.green_in, if_s3.blue_in} = 12'h000;
        test_reset();
        test_line_full();
        test_frames();
        test_colour_const();
        test_mid_reset();
        test_pipe3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
